// File: rtl/multibuffer_queue.sv
// multibuffer_queue: banked FIFO taking 128-bit words of two packed entries
// and draining one DATA_OUT_WIDTH entry per read with one cycle of latency.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   write_en     push both entries of data_in (dropped while full)
//   data_in      entry0 in the low half, entry1 in the high half
//   waitrequest  write would be refused this cycle (same as full)
//   read_en      pop one entry (ignored while empty)
//   data_out     last entry delivered by a successful read
//   data_valid   data_out was updated by a read this cycle
//   full         fewer than two free entry slots
//   empty        no stored entries
//   almost_full  count >= CAP - CAP/M_BUFF_NUM
module multibuffer_queue #(
  parameter int unsigned Q_DATA_WIDTH      = 128,
  parameter int unsigned M_BUFF_NUM        = 4,
  parameter int unsigned M_BUFF_ADDR_WIDTH = 10,
  parameter int unsigned DATA_OUT_WIDTH    = 42
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [Q_DATA_WIDTH-1:0]   data_in,
  output logic                      waitrequest,
  input  logic                      read_en,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full
);

  localparam int unsigned AW    = M_BUFF_ADDR_WIDTH;
  localparam int unsigned CAP   = 1 << AW;
  localparam int unsigned BW    = $clog2(M_BUFF_NUM);
  localparam int unsigned DEPTH = CAP / M_BUFF_NUM;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DW    = DATA_OUT_WIDTH;
  localparam int unsigned HALF  = Q_DATA_WIDTH / 2;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;

  logic          do_write;
  logic          do_read;
  logic [AW-1:0] wptr1;
  logic [DW-1:0] entry0;
  logic [DW-1:0] entry1;
  logic [DW-1:0] bank_rd [M_BUFF_NUM];
  logic [DW-1:0] rd_word;
  logic          unused_data;

  // Flags derive from the registered count only.
  assign full        = count_q > CW'(CAP - 2);
  assign waitrequest = full;
  assign empty       = (count_q == '0);
  assign almost_full = count_q >= CW'(CAP - DEPTH);

  assign do_write = write_en && !full;
  assign do_read  = read_en && !empty;

  assign entry0 = data_in[DW-1:0];
  assign entry1 = data_in[HALF+DW-1:HALF];
  assign wptr1  = wptr_q + AW'(1);
  // Bits between and above the two entry fields are don't-care.
  assign unused_data = ^data_in;

  // Entry p lives in bank p[BW-1:0] at row p[AW-1:BW]; a word's two entries
  // always land in two different banks, so each bank sees one write port.
  for (genvar b = 0; b < M_BUFF_NUM; b++) begin : g_bank
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
      if (do_write && (wptr_q[BW-1:0] == BW'(b))) mem_q[wptr_q[AW-1:BW]] <= entry0;
      if (do_write && (wptr1[BW-1:0] == BW'(b)))  mem_q[wptr1[AW-1:BW]]  <= entry1;
    end

    assign bank_rd[b] = mem_q[rd_addr_q[AW-1:BW]];
  end

  assign rd_word = bank_rd[rd_addr_q[BW-1:0]];

  // Next-state: pointers, count, and the one-deep read pipeline.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    rd_pend_d    = do_read;
    rd_addr_d    = rd_addr_q;
    data_out_d   = data_out_q;
    data_valid_d = rd_pend_q;

    if (do_write) wptr_d = wptr_q + AW'(2);
    if (do_read) begin
      rptr_d    = rptr_q + AW'(1);
      rd_addr_d = rptr_q;
    end

    unique case ({do_write, do_read})
      2'b10:   count_d = count_q + CW'(2);
      2'b01:   count_d = count_q - CW'(1);
      2'b11:   count_d = count_q + CW'(1);
      default: count_d = count_q;
    endcase

    // Entry popped last cycle is fetched from its bank now.
    if (rd_pend_q) data_out_d = rd_word;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rd_pend_q    <= 1'b0;
      rd_addr_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rd_pend_q    <= rd_pend_d;
      rd_addr_q    <= rd_addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_multibuffer_queue.sv
// tb_multibuffer_queue: directed vector table plus hand-written sequences
// for fill/overfill, drain past empty, concurrent streaming and mid-stream
// reset of multibuffer_queue (default parameters).
module tb_multibuffer_queue;

  logic         clk;
  logic         rst;
  logic         write_en;
  logic [127:0] data_in;
  logic         waitrequest;
  logic         read_en;
  logic [41:0]  data_out;
  logic         data_valid;
  logic         full;
  logic         empty;
  logic         almost_full;

  int nvec;
  int nerr;

  multibuffer_queue dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .data_in     (data_in),
    .waitrequest (waitrequest),
    .read_en     (read_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         we;
    logic [127:0] din;
    logic         re;
    logic         ev;
    logic [41:0]  ed;
    logic         ee;
    logic         ef;
    logic         eaf;
  } vec_t;

  vec_t        tv [19];
  logic [31:0] seq [10];

  int wr_idx, wr_guard, rx_idx, rx_guard, cnt;
  logic wr_acc;

  function automatic logic [41:0] mk(input logic [31:0] a);
    return {10'h223, a};
  endfunction

  // Ignored bits are set to 1 so a design that leaks them is noticed.
  function automatic logic [127:0] pack(input logic [41:0] e0, input logic [41:0] e1);
    logic [127:0] w;
    w = {128{1'b1}};
    w[41:0]   = e0;
    w[105:64] = e1;
    return w;
  endfunction

  function automatic vec_t mkv(input logic rst_n, input logic we, input logic [127:0] din,
                               input logic re, input logic ev, input logic [41:0] ed,
                               input logic ee, input logic ef, input logic eaf);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.din = din; v.re = re;
    v.ev = ev; v.ed = ed; v.ee = ee; v.ef = ef; v.eaf = eaf;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [41:0] act, input logic [41:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;

    seq[0] = 32'h0;   seq[1] = 32'hfffffff; seq[2] = 32'h300; seq[3] = 32'h2;
    seq[4] = 32'h500; seq[5] = 32'hfff33ff; seq[6] = 32'h600; seq[7] = 32'hf444fff;
    seq[8] = 32'h600; seq[9] = 32'hf444fff;

    // Reset overrides concurrent read and write requests.
    tv[0] = mkv(1'b0, 1'b1, pack(mk(32'h1), mk(32'h2)), 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      tv[1+k] = mkv(1'b1, 1'b1, pack(mk(seq[2*k]), mk(seq[2*k+1])), 1'b0,
                    1'b0, '0, 1'b0, 1'b0, 1'b0);
    tv[6] = mkv(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      tv[7+k] = mkv(1'b1, 1'b0, '0, 1'b1, 1'b1, mk(seq[k]), (k >= 8), 1'b0, 1'b0);
    tv[17] = mkv(1'b1, 1'b0, '0, 1'b1, 1'b0, mk(seq[9]), 1'b1, 1'b0, 1'b0);
    tv[18] = mkv(1'b1, 1'b0, '0, 1'b0, 1'b0, mk(seq[9]), 1'b1, 1'b0, 1'b0);

    for (int v = 0; v < 19; v++) begin
      rst = tv[v].rst_n; write_en = tv[v].we; data_in = tv[v].din; read_en = tv[v].re;
      tick();
      chk1($sformatf("tv%0d_valid", v), data_valid, tv[v].ev);
      chkd($sformatf("tv%0d_data", v), data_out, tv[v].ed);
      chk1($sformatf("tv%0d_empty", v), empty, tv[v].ee);
      chk1($sformatf("tv%0d_full", v), full, tv[v].ef);
      chk1($sformatf("tv%0d_waitreq", v), waitrequest, tv[v].ef);
      chk1($sformatf("tv%0d_afull", v), almost_full, tv[v].eaf);
    end

    // Fill from empty (pointers start mid-array, so this wraps).
    cnt = 0;
    read_en = 1'b0;
    for (int w = 0; w < 512; w++) begin
      write_en = 1'b1;
      data_in  = pack(mk(32'(2*w)), mk(32'(2*w+1)));
      chk1($sformatf("fill%0d_waitreq", w), waitrequest, 1'b0);
      tick();
      cnt += 2;
      chk1($sformatf("fill%0d_full", w), full, (cnt > 1022));
      chk1($sformatf("fill%0d_afull", w), almost_full, (cnt >= 768));
    end

    // Overfill attempts must be dropped.
    for (int k = 0; k < 3; k++) begin
      write_en = 1'b1;
      data_in  = pack(mk(32'hdead0000 + 32'(k)), mk(32'hbeef0000 + 32'(k)));
      chk1($sformatf("over%0d_waitreq", k), waitrequest, 1'b1);
      tick();
      chk1($sformatf("over%0d_full", k), full, 1'b1);
    end
    write_en = 1'b0;

    // Drain everything, then read past empty.
    for (int j = 0; j < 1026; j++) begin
      read_en = 1'b1;
      tick();
      if (j >= 1 && j <= 1024) begin
        chk1($sformatf("drain%0d_valid", j), data_valid, 1'b1);
        chkd($sformatf("drain%0d_data", j), data_out, mk(32'(j-1)));
      end else if (j == 1025) begin
        chk1("past_empty_valid", data_valid, 1'b0);
        chkd("past_empty_data", data_out, mk(32'd1023));
        chk1("past_empty_empty", empty, 1'b1);
        chk1("past_empty_full", full, 1'b0);
      end
    end
    read_en = 1'b0;
    tick();

    // Concurrent writer and late-starting reader.
    wr_idx = 0; wr_guard = 0; rx_idx = 0; rx_guard = 0;
    fork
      begin
        while (wr_idx < 1024 && wr_guard < 5000) begin
          write_en = 1'b1;
          data_in  = pack(mk(32'(wr_idx)), mk(32'(wr_idx+1)));
          wr_acc   = !waitrequest;
          tick();
          if (wr_acc) wr_idx += 2;
          wr_guard++;
        end
        write_en = 1'b0;
      end
      begin
        repeat (55) tick();
        read_en = 1'b1;
        while (rx_idx < 1024 && rx_guard < 6000) begin
          tick();
          if (data_valid) begin
            chkd($sformatf("stream%0d", rx_idx), data_out, mk(32'(rx_idx)));
            rx_idx++;
          end
          rx_guard++;
        end
        read_en = 1'b0;
      end
    join
    chki("stream_written", wr_idx, 1024);
    chki("stream_received", rx_idx, 1024);
    tick();
    chk1("stream_end_empty", empty, 1'b1);

    // Reset in the middle of a read burst.
    write_en = 1'b1; read_en = 1'b0;
    data_in = pack(mk(32'h100), mk(32'h101));
    tick();
    data_in = pack(mk(32'h102), mk(32'h103));
    tick();
    read_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk1("rst_valid", data_valid, 1'b0);
    chkd("rst_data", data_out, '0);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk1("rst_afull", almost_full, 1'b0);
    chk1("rst_waitreq", waitrequest, 1'b0);

    rst = 1'b1; write_en = 1'b1; read_en = 1'b0;
    data_in = pack(mk(32'h777), mk(32'h778));
    tick();
    chk1("post_rst_empty", empty, 1'b0);
    write_en = 1'b0; read_en = 1'b1;
    tick();
    chk1("post_rst_prime_valid", data_valid, 1'b0);
    tick();
    chk1("post_rst_rd0_valid", data_valid, 1'b1);
    chkd("post_rst_rd0_data", data_out, mk(32'h777));
    read_en = 1'b0;
    tick();
    chk1("post_rst_rd1_valid", data_valid, 1'b1);
    chkd("post_rst_rd1_data", data_out, mk(32'h778));
    chk1("post_rst_rd1_empty", empty, 1'b1);
    tick();
    chk1("post_rst_idle_valid", data_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multibuffer_queue.md
Name: multibuffer_queue

Overview:
Multi-bank FIFO that accepts wide 128-bit write words and drains them as narrower entries, one entry per read. Each write word carries two packed entries. The lower half is read out first, then the upper half. The block sits between a trace/request producer (wide writes with backpressure via waitrequest) and a memory-access consumer (one {info, address} record per read). Storage is split across M_BUFF_NUM interleaved banks.

Parameters:
Q_DATA_WIDTH, 128, write word width; holds 2 entry slots of Q_DATA_WIDTH/2 bits.
M_BUFF_NUM, 4, number of storage banks (power of 2); consecutive entries go to consecutive banks, round-robin.
M_BUFF_ADDR_WIDTH, 10, total entry capacity CAP = 2^M_BUFF_ADDR_WIDTH; each bank holds CAP/M_BUFF_NUM entries.
DATA_OUT_WIDTH, 42, output entry width; must be <= Q_DATA_WIDTH/2.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-low (rst==0 at a rising edge resets).
write_en  in  1  write request for data_in.
data_in  in  Q_DATA_WIDTH  entry0 = data_in[DATA_OUT_WIDTH-1:0]; entry1 = data_in[Q_DATA_WIDTH/2+DATA_OUT_WIDTH-1:Q_DATA_WIDTH/2]; other bits ignored.
waitrequest  out  1  high = write would be refused this cycle.
read_en  in  1  pop one entry.
data_out  out  DATA_OUT_WIDTH  last successfully read entry.
data_valid  out  1  one-cycle flag: data_out was updated by a successful read.
full  out  1  fewer than 2 free entry slots.
empty  out  1  zero stored entries.
almost_full  out  1  count >= CAP - CAP/M_BUFF_NUM.

Behaviour:
- State: write pointer, read pointer (both log2(CAP) bits, wrapping modulo CAP), entry count (0..CAP), output register, valid register.
- Reset (rst==0 at edge): pointers=0, count=0, data_out=0, data_valid=0. Outputs after reset: empty=1, full=0, almost_full=0, waitrequest=0. Reset overrides any concurrent read/write, including mid-burst.
- Flags are combinational from the registered count:
  - full = (count > CAP-2)
  - waitrequest = full
  - empty = (count == 0)
- Write: at an edge with write_en && !full, entry0 is stored at wptr and entry1 at wptr+1; wptr += 2; count += 2.
- Refused write: write_en while full is silently dropped; no state change.
- Read issue: at edge k, read_en && !empty pops the entry at rptr; rptr += 1; count -= 1.
- Read latency: one bank/RAM cycle. The popped entry appears on data_out after edge k+1, with data_valid=1 for exactly that cycle.
  - Consequence: the first read of a burst primes the pipeline. The value seen after the edge following read N is entry N-1.
- Empty read: read_en while empty pops nothing. After edge k+1, data_valid=0 and data_out holds its previous value.
- Idle: with read_en low, data_valid=0 and data_out holds.
- Simultaneous write and read in one cycle:
  - Both act, with flags evaluated on the pre-edge count; net count += 1.
  - An entry written in cycle k can first be popped in cycle k+1.
- Ordering: strict FIFO in entry order (word0.lo, word0.hi, word1.lo, …) across pointer wrap-around.
- Count never exceeds CAP and never underflows.

Test Plan:
- Reset, then write 5 words with addr pairs (0x0000000,0xfffffff), (0x300,0x2), (0x500,0xfff33ff), (0x600,0xf444fff), (0x600,0xf444fff), all with info=0x223. Issue one priming read, then 10 reads → data_out low 32 bits in sequence 0x0,0xfffffff,0x300,0x2,0x500,0xfff33ff,0x600,0xf444fff,0x600,0xf444fff; info field = 0x223 each; data_valid=1 each.
- From empty, write 512 words (i,i+1), i=0,2,…,1022 → full/waitrequest rise after word i=1022 (count=1024); almost_full rises at count>=768; no entry dropped.
- Overfill: after full, continue writes → waitrequest=1, count stays CAP; readback returns 0..1023 only.
- Drain past empty: continue reads after the last entry → data_valid=0, data_out holds the last valid address; empty=1.
- Concurrent stream: writer pushes 0..1023 in pairs, retrying while waitrequest=1. Reader starts about 55 cycles later, retrying on data_valid=0 → all 1024 addresses received in order, no duplicates or gaps.
- Assert rst=0 mid-stream with read_en=1 → next cycle data_valid=0, data_out=0, empty=1; subsequent writes restart at index 0.
